// File: rtl/int_service_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// int_service_ctrl_pkg
// Shared constants for the interrupt service controller.
//   N_IRQ_DEF : default number of interrupt sources
//   IRQ_HI/IRQ_MID/IRQ_LO : bit index of each priority level
//                           (the highest index has the highest priority)
//   VEC_W     : width of the one-hot grant / request vectors
// ----------------------------------------------------------------------------
package int_service_ctrl_pkg;

    localparam int unsigned N_IRQ_DEF = 3;

    localparam int unsigned IRQ_HI  = 2;
    localparam int unsigned IRQ_MID = 1;
    localparam int unsigned IRQ_LO  = 0;

    localparam int unsigned VEC_W = N_IRQ_DEF;

endpackage : int_service_ctrl_pkg

// File: rtl/int_service_ctrl_hi_bit.sv
// ----------------------------------------------------------------------------
// int_hi_bit
// Combinational highest-set-bit extractor. Returns a one-hot vector with only
// the most significant set bit of vec_i kept; all-zero when vec_i is zero.
// Ports:
//   vec_i    : input vector
//   onehot_o : one-hot of the highest set bit of vec_i
// ----------------------------------------------------------------------------
module int_hi_bit #(
    parameter int unsigned Width = 3
) (
    input  logic [Width-1:0] vec_i,
    output logic [Width-1:0] onehot_o
);

    // Ascending scan: the last (highest) set bit found overwrites earlier ones.
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (vec_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule : int_hi_bit

// File: rtl/int_service_ctrl.sv
// ----------------------------------------------------------------------------
// int_service_ctrl
// Per-source interrupt controller: captures rising edges of the device lines
// into the pending register (IR), tracks in-service levels (IRS), and presents
// one registered, prioritised grant to the pipeline.
//
// Build option: define INT_NEST_EN to allow a higher source to preempt a lower
// in-service level. Without it only one level can be in service at a time.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   irq_in   : raw device request lines (synchronous to clk)
//   int_en   : global interrupt enable
//   int_ack  : pipeline accepts the presented int_vec (one-cycle pulse)
//   int_ret  : eret retired, ends the highest in-service level (pulse)
//   int_req  : registered, a grant is presented
//   int_vec  : registered one-hot grant, zero when int_req is low
//   IR       : pending-request register
//   IRS      : in-service register
// ----------------------------------------------------------------------------
module int_service_ctrl
    import int_service_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ = N_IRQ_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_en,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [N_IRQ-1:0] int_vec,
    output logic [N_IRQ-1:0] IR,
    output logic [N_IRQ-1:0] IRS
);

    logic [N_IRQ-1:0] irq_hist_q;
    logic [N_IRQ-1:0] ir_q, ir_d;
    logic [N_IRQ-1:0] irs_q, irs_d;
    logic [N_IRQ-1:0] vec_q, vec_d;
    logic             req_q, req_d;

    logic [N_IRQ-1:0] irs_hi;
    logic [N_IRQ-1:0] prio_gate;
    logic [N_IRQ-1:0] cand_raw;
    logic             ack_eff;

    // An ack with nothing presented is ignored entirely.
    assign ack_eff = int_ack & req_q;

    int_hi_bit #(
        .Width (N_IRQ)
    ) u_irs_hi (
        .vec_i    (irs_q),
        .onehot_o (irs_hi)
    );

    always_comb begin
        // A fresh edge on the same bit as the acked grant is a new request: set wins.
        ir_d = ir_q;
        if (ack_eff) begin
            ir_d = ir_d & ~vec_q;
        end
        ir_d = ir_d | (irq_in & ~irq_hist_q);

        irs_d = irs_q;
        if (int_ret) begin
            irs_d = irs_d & ~irs_hi;
        end
        if (ack_eff) begin
            irs_d = irs_d | vec_q;
        end
    end

    // prio_gate[i] is set when no in-service bit sits at or above i, i.e. a
    // pending bit i would be strictly higher than the top in-service level.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        prio_gate = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            seen         = seen | irs_d[i];
            prio_gate[i] = ~seen;
        end
    end

    int_hi_bit #(
        .Width (N_IRQ)
    ) u_cand_hi (
        .vec_i    (ir_d & prio_gate),
        .onehot_o (cand_raw)
    );

    always_comb begin
        logic [N_IRQ-1:0] cand;
`ifdef INT_NEST_EN
        cand = cand_raw;
`else
        cand = (|irs_d) ? '0 : cand_raw;
`endif
        vec_d = int_en ? cand : '0;
        req_d = |vec_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_hist_q <= '0;
            ir_q       <= '0;
            irs_q      <= '0;
            vec_q      <= '0;
            req_q      <= 1'b0;
        end else begin
            irq_hist_q <= irq_in;
            ir_q       <= ir_d;
            irs_q      <= irs_d;
            vec_q      <= vec_d;
            req_q      <= req_d;
        end
    end

    assign int_req = req_q;
    assign int_vec = vec_q;
    assign IR      = ir_q;
    assign IRS     = irs_q;

endmodule : int_service_ctrl

// File: tb/tb_int_service_ctrl.sv
module tb_int_service_ctrl;

    import int_service_ctrl_pkg::*;

    localparam int unsigned N = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         int_en;
    logic         int_ack;
    logic         int_ret;
    logic         int_req;
    logic [N-1:0] int_vec;
    logic [N-1:0] IR;
    logic [N-1:0] IRS;

    int checks;
    int passed;

    int_service_ctrl #(
        .N_IRQ (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .int_en  (int_en),
        .int_ack (int_ack),
        .int_ret (int_ret),
        .int_req (int_req),
        .int_vec (int_vec),
        .IR      (IR),
        .IRS     (IRS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] e_ir, input logic [N-1:0] e_irs,
                             input logic e_req, input logic [N-1:0] e_vec);
        check({tag, ".IR"},  32'(IR),      32'(e_ir));
        check({tag, ".IRS"}, 32'(IRS),     32'(e_irs));
        check({tag, ".req"}, 32'(int_req), 32'(e_req));
        check({tag, ".vec"}, 32'(int_vec), 32'(e_vec));
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b1;
        irq_in  = '0;
        int_en  = 1'b0;
        int_ack = 1'b0;
        int_ret = 1'b0;
        tick();
        check_all("reset", 3'b000, 3'b000, 1'b0, 3'b000);
        rst = 1'b0;

        // Edge on the middle source: granted from the same edge.
        irq_in = 3'b010;
        int_en = 1'b1;
        tick();
        check_all("edge_mid", 3'b010, 3'b000, 1'b1, 3'b010);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("ack_mid", 3'b000, 3'b010, 1'b0, 3'b000);

`ifdef INT_NEST_EN
        // High and low edges together while mid is in service: high preempts.
        irq_in = 3'b111;
        tick();
        check_all("nest_pre", 3'b101, 3'b010, 1'b1, 3'b100);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("nest_ack", 3'b001, 3'b110, 1'b0, 3'b000);

        int_ret = 1'b1;
        tick();
        check_all("ret1", 3'b001, 3'b010, 1'b0, 3'b000);

        tick();
        int_ret = 1'b0;
        check_all("ret2", 3'b001, 3'b000, 1'b1, 3'b001);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("ack_lo", 3'b000, 3'b001, 1'b0, 3'b000);

        // Re-edge the high source; it preempts the in-service low level.
        irq_in = 3'b011;
        tick();
        irq_in = 3'b111;
        tick();
        check_all("hi_over_lo", 3'b100, 3'b001, 1'b1, 3'b100);

        irq_in = 3'b011;
        tick();
        check_all("hi_held", 3'b100, 3'b001, 1'b1, 3'b100);

        // ack + ret + new edge on the acked bit in one cycle.
        irq_in  = 3'b111;
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        check_all("ack_ret_set", 3'b100, 3'b100, 1'b0, 3'b000);
`else
        // Single-level build: nothing is granted while mid is in service.
        irq_in = 3'b111;
        tick();
        check_all("single_block", 3'b101, 3'b010, 1'b0, 3'b000);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("ack_ignored", 3'b101, 3'b010, 1'b0, 3'b000);

        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check_all("ret_grant_hi", 3'b101, 3'b000, 1'b1, 3'b100);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("ack_hi", 3'b001, 3'b100, 1'b0, 3'b000);

        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check_all("ret_grant_lo", 3'b001, 3'b000, 1'b1, 3'b001);

        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("ack_lo", 3'b000, 3'b001, 1'b0, 3'b000);

        // High pending while low in service: blocked until int_ret.
        irq_in = 3'b011;
        tick();
        irq_in = 3'b111;
        tick();
        check_all("hi_blocked", 3'b100, 3'b001, 1'b0, 3'b000);
        tick();
        check_all("hi_blocked2", 3'b100, 3'b001, 1'b0, 3'b000);

        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check_all("hi_after_ret", 3'b100, 3'b000, 1'b1, 3'b100);

        irq_in = 3'b011;
        tick();

        // ack + ret (IRS empty, no-op) + new edge on the acked bit.
        irq_in  = 3'b111;
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        check_all("ack_ret_set", 3'b100, 3'b100, 1'b0, 3'b000);
`endif

        // int_en gating from a clean state.
        rst = 1'b1;
        irq_in = '0;
        int_en = 1'b0;
        #1;
        check_all("reset2", 3'b000, 3'b000, 1'b0, 3'b000);
        tick();
        rst = 1'b0;

        irq_in[IRQ_HI] = 1'b1;
        tick();
        check_all("en_off", 3'b100, 3'b000, 1'b0, 3'b000);
        tick();
        check_all("en_off_hold", 3'b100, 3'b000, 1'b0, 3'b000);

        int_en = 1'b1;
        tick();
        check_all("en_on", 3'b100, 3'b000, 1'b1, 3'b100);

        int_en = 1'b0;
        tick();
        check_all("en_drop", 3'b100, 3'b000, 1'b0, 3'b000);

        int_en = 1'b1;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_all("svc_hi", 3'b000, 3'b100, 1'b0, 3'b000);

        // Asynchronous reset mid-service, observed before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 3'b000, 3'b000, 1'b0, 3'b000);
        irq_in = '0;
        tick();
        rst = 1'b0;
        tick();
        check_all("post_rst", 3'b000, 3'b000, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_int_service_ctrl
